// File: rtl/eforth1_stack.sv
// Cached-top stack engine: TOS/NOS in registers, deeper cells in a synchronous single-port RAM.
// Define EFORTH1_SS_GUARD_EN to reject overflow/underflow/bad-pick and raise sticky err.
module eforth1_stack #(
  parameter  int DEPTH = 64,
  parameter  int DSZ   = 16,
  localparam int SSZ   = $clog2(DEPTH)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           en,
  input  logic [1:0]     op,
  input  logic [DSZ-1:0] vi,
  output logic [DSZ-1:0] t,
  output logic [DSZ-1:0] s,
  output logic [SSZ-1:0] sp0,
  output logic [SSZ-1:0] sp1,
  output logic [SSZ:0]   depth,
  output logic           busy,
  output logic           empty,
  output logic           full,
  output logic           err
);

  localparam logic [1:0] SS_SET  = 2'b00;
  localparam logic [1:0] SS_PUSH = 2'b01;
  localparam logic [1:0] SS_POP  = 2'b10;
  localparam logic [1:0] SS_PICK = 2'b11;

  localparam logic [SSZ:0]   DEPTH_MAX = (SSZ+1)'(DEPTH);
  localparam logic [SSZ-1:0] IDX_ONE   = SSZ'(1);
  localparam logic [SSZ:0]   CNT_ONE   = (SSZ+1)'(1);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_FILL = 1'b1
  } state_e;

  state_e state_q, state_d;

  logic [DSZ-1:0] t_q, s_q;
  logic [SSZ-1:0] sp0_q, sp1_q;
  logic [SSZ:0]   depth_q;
  logic           fill_to_t_q;

  logic [DSZ-1:0] mem [DEPTH];
  logic [DSZ-1:0] rd_data_p1;

  logic [SSZ-1:0] pick_k;
  logic           accept;
  logic           is_full, is_empty;
  logic           push_bad, pop_bad, pick_bad;
  logic           do_set, do_push, do_pop, do_pick0, do_pickn;
  logic           ram_we, ram_re;
  logic [SSZ-1:0] ram_addr;

  assign pick_k   = vi[SSZ-1:0];
  assign accept   = en && (state_q == ST_IDLE);
  assign is_full  = (depth_q == DEPTH_MAX);
  assign is_empty = (depth_q == '0);

`ifdef EFORTH1_SS_GUARD_EN
  assign push_bad = is_full;
  assign pop_bad  = is_empty;
  assign pick_bad = (pick_k != '0) && ({1'b0, pick_k} > depth_q);
`else
  assign push_bad = 1'b0;
  assign pop_bad  = 1'b0;
  assign pick_bad = 1'b0;
`endif

  always_comb begin
    do_set   = 1'b0;
    do_push  = 1'b0;
    do_pop   = 1'b0;
    do_pick0 = 1'b0;
    do_pickn = 1'b0;
    if (accept) begin
      case (op)
        SS_SET:  do_set  = 1'b1;
        SS_PUSH: do_push = !push_bad;
        SS_POP:  do_pop  = !pop_bad;
        SS_PICK: begin
          do_pick0 = (pick_k == '0);
          do_pickn = (pick_k != '0) && !pick_bad;
        end
        default: ;
      endcase
    end
  end

  // Single port: a PUSH writes, a POP/PICK reads, never both in one cycle
  always_comb begin
    ram_we   = do_push;
    ram_re   = do_pop || do_pickn;
    ram_addr = sp0_q - pick_k;
    if (do_push)
      ram_addr = sp1_q;
    else if (do_pop)
      ram_addr = sp0_q - IDX_ONE;
  end

  // Stage p0 -> p1: RAM access; read data is consumed during FILL
  always_ff @(posedge clk) begin
    if (ram_we)
      mem[ram_addr] <= t_q;
    else if (ram_re)
      rd_data_p1 <= mem[ram_addr];
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (ram_re) state_d = ST_FILL;
      ST_FILL: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      fill_to_t_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (ram_re)
        fill_to_t_q <= do_pickn;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      t_q     <= '0;
      s_q     <= '0;
      sp0_q   <= SSZ'(DEPTH - 1);
      sp1_q   <= '0;
      depth_q <= '0;
    end else if (state_q == ST_FILL) begin
      if (fill_to_t_q)
        t_q <= rd_data_p1;
      else
        s_q <= rd_data_p1;
    end else begin
      if (do_set || do_push)
        t_q <= vi;
      if (do_pop || do_pick0)
        t_q <= s_q;
      if (do_push) begin
        s_q   <= t_q;
        sp0_q <= sp1_q;
        sp1_q <= sp1_q + IDX_ONE;
        if (!is_full)
          depth_q <= depth_q + CNT_ONE;
      end
      if (do_pop) begin
        sp1_q <= sp0_q;
        sp0_q <= sp0_q - IDX_ONE;
        if (!is_empty)
          depth_q <= depth_q - CNT_ONE;
      end
    end
  end

`ifdef EFORTH1_SS_GUARD_EN
  logic err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      err_q <= 1'b0;
    else if (accept && (((op == SS_PUSH) && push_bad) ||
                        ((op == SS_POP)  && pop_bad)  ||
                        ((op == SS_PICK) && pick_bad)))
      err_q <= 1'b1;
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  assign t     = t_q;
  assign s     = s_q;
  assign sp0   = sp0_q;
  assign sp1   = sp1_q;
  assign depth = depth_q;
  assign busy  = (state_q == ST_FILL);
  assign empty = is_empty;
  assign full  = is_full;

endmodule

// File: tb/tb_eforth1_stack.sv
// Directed bench for eforth1_stack (DEPTH=64, DSZ=16); expected values worked out by hand.
module tb_eforth1_stack;

  localparam logic [1:0] SS_SET  = 2'b00;
  localparam logic [1:0] SS_PUSH = 2'b01;
  localparam logic [1:0] SS_POP  = 2'b10;
  localparam logic [1:0] SS_PICK = 2'b11;

  logic        clk;
  logic        rst_n;
  logic        en;
  logic [1:0]  op;
  logic [15:0] vi;
  logic [15:0] t, s;
  logic [5:0]  sp0, sp1;
  logic [6:0]  depth;
  logic        busy, empty, full, err;

  int checks   = 0;
  int failures = 0;

  eforth1_stack #(.DEPTH(64), .DSZ(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (en),
    .op    (op),
    .vi    (vi),
    .t     (t),
    .s     (s),
    .sp0   (sp0),
    .sp1   (sp1),
    .depth (depth),
    .busy  (busy),
    .empty (empty),
    .full  (full),
    .err   (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge: drives one op, returns at the next negedge
  task automatic issue(input logic [1:0] o, input logic [15:0] v);
    en = 1'b1;
    op = o;
    vi = v;
    @(negedge clk);
    en = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0;
    en    = 1'b0;
    op    = SS_SET;
    vi    = '0;
    @(negedge clk);
    chk("rst_hold_sp0", 32'(sp0), 32'd63);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("rst_t", 32'(t), 32'h0);
    chk("rst_s", 32'(s), 32'h0);
    chk("rst_sp0", 32'(sp0), 32'd63);
    chk("rst_sp1", 32'(sp1), 32'd0);
    chk("rst_depth", 32'(depth), 32'd0);
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_err", 32'(err), 32'd0);

    // Pushes then a pop with refill
    issue(SS_PUSH, 16'h1111);
    issue(SS_PUSH, 16'h2222);
    issue(SS_PUSH, 16'h3333);
    chk("push_t", 32'(t), 32'h3333);
    chk("push_s", 32'(s), 32'h2222);
    chk("push_depth", 32'(depth), 32'd3);
    chk("push_sp0", 32'(sp0), 32'd2);
    chk("push_sp1", 32'(sp1), 32'd3);
    chk("push_empty", 32'(empty), 32'd0);
    issue(SS_POP, 16'h0);
    chk("pop_t", 32'(t), 32'h2222);
    chk("pop_busy", 32'(busy), 32'd1);
    chk("pop_depth", 32'(depth), 32'd2);
    @(negedge clk);
    chk("pop_busy_done", 32'(busy), 32'd0);
    chk("pop_s", 32'(s), 32'h1111);
    chk("pop_sp0", 32'(sp0), 32'd1);
    chk("pop_sp1", 32'(sp1), 32'd2);

    // SET touches only t
    issue(SS_SET, 16'hBEEF);
    chk("set_t", 32'(t), 32'hBEEF);
    chk("set_s", 32'(s), 32'h1111);
    chk("set_depth", 32'(depth), 32'd2);

    // PICK: RAM holds 0,A,B,C at 0..3, s=C, t=D, sp0=3
    do_reset();
    issue(SS_PUSH, 16'h000A);
    issue(SS_PUSH, 16'h000B);
    issue(SS_PUSH, 16'h000C);
    issue(SS_PUSH, 16'h000D);
    chk("pk_pre_t", 32'(t), 32'hD);
    chk("pk_pre_s", 32'(s), 32'hC);
    issue(SS_PICK, 16'd2);
    chk("pick2_busy", 32'(busy), 32'd1);
    chk("pick2_t_hold", 32'(t), 32'hD);
    @(negedge clk);
    chk("pick2_t", 32'(t), 32'hA);
    chk("pick2_s", 32'(s), 32'hC);
    chk("pick2_depth", 32'(depth), 32'd4);
    chk("pick2_sp0", 32'(sp0), 32'd3);
    chk("pick2_busy_done", 32'(busy), 32'd0);
    issue(SS_PICK, 16'd1);
    @(negedge clk);
    chk("pick1_t", 32'(t), 32'hB);
    issue(SS_PICK, 16'd0);
    chk("pick0_t", 32'(t), 32'hC);
    chk("pick0_busy", 32'(busy), 32'd0);

    // en during FILL is ignored
    issue(SS_POP, 16'h0);
    chk("ign_busy", 32'(busy), 32'd1);
    chk("ign_pop_t", 32'(t), 32'hC);
    issue(SS_SET, 16'h0055);
    chk("ign_t", 32'(t), 32'hC);
    chk("ign_s", 32'(s), 32'hB);
    chk("ign_depth", 32'(depth), 32'd3);
    chk("ign_busy_done", 32'(busy), 32'd0);

    // Fill to full
    do_reset();
    for (int i = 1; i <= 64; i++) issue(SS_PUSH, 16'(i));
    chk("full_flag", 32'(full), 32'd1);
    chk("full_depth", 32'(depth), 32'd64);
    chk("full_t", 32'(t), 32'h40);
    chk("full_s", 32'(s), 32'h3F);
    chk("full_sp1", 32'(sp1), 32'd0);
    issue(SS_PUSH, 16'h0099);
`ifdef EFORTH1_SS_GUARD_EN
    chk("ovf_t", 32'(t), 32'h40);
    chk("ovf_sp1", 32'(sp1), 32'd0);
    chk("ovf_err", 32'(err), 32'd1);
`else
    chk("ovf_t", 32'(t), 32'h99);
    chk("ovf_sp1", 32'(sp1), 32'd1);
    chk("ovf_err", 32'(err), 32'd0);
`endif
    chk("ovf_depth", 32'(depth), 32'd64);
    chk("ovf_full", 32'(full), 32'd1);

    // Underflow
    do_reset();
    issue(SS_POP, 16'h0);
`ifdef EFORTH1_SS_GUARD_EN
    chk("udf_busy", 32'(busy), 32'd0);
    chk("udf_sp0", 32'(sp0), 32'd63);
    chk("udf_err", 32'(err), 32'd1);
`else
    chk("udf_err", 32'(err), 32'd0);
`endif
    chk("udf_depth", 32'(depth), 32'd0);
    chk("udf_empty", 32'(empty), 32'd1);
    @(negedge clk);

    // Reset mid-FILL
    do_reset();
    issue(SS_PUSH, 16'h0005);
    issue(SS_PUSH, 16'h0006);
    issue(SS_POP, 16'h0);
    chk("mid_busy", 32'(busy), 32'd1);
    chk("mid_t", 32'(t), 32'h5);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_t", 32'(t), 32'h0);
    chk("mid_rst_s", 32'(s), 32'h0);
    chk("mid_rst_depth", 32'(depth), 32'd0);
    chk("mid_rst_sp0", 32'(sp0), 32'd63);
    chk("mid_rst_sp1", 32'(sp1), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("mid_rel_busy", 32'(busy), 32'd0);
    chk("mid_rel_t", 32'(t), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
